// File: rtl/jpeg_enc_pkg.sv
// Shared types for the JPEG entropy front-end: symbol word layout, field
// positions and the run-length encoder FSM states.
package jpeg_enc_pkg;

   localparam int SYM_SIZE_LSB = 0;
   localparam int SYM_RUN_LSB  = 4;
   localparam int SYM_DC_BIT   = 8;
   localparam int SYM_EOB_BIT  = 9;
   localparam int SYM_ZRL_BIT  = 10;
   localparam int SYM_AMP_LSB  = 16;
   localparam int SYM_AMP_W    = 16;

   localparam logic [3:0] ZRL_RUN = 4'd15;

   // Packed MSB-first so the struct bit positions match the constants above.
   typedef struct packed {
      logic [SYM_AMP_W-1:0] amp;
      logic [4:0]           zero;
      logic                 zrl;
      logic                 eob;
      logic                 dc;
      logic [3:0]           run;
      logic [3:0]           size;
   } rle_sym_t;

   typedef enum logic [0:0] {
      ST_COEF = 1'b0,
      ST_ZRL  = 1'b1
   } rle_state_t;

endpackage

// File: rtl/jpeg_vli_enc.sv
// JPEG VLI category coder: signed value -> (size, amplitude). Negative values
// are coded as (v-1) truncated to size bits; upper amplitude bits are zero.
module jpeg_vli_enc
   import jpeg_enc_pkg::*;
#(
   parameter int W = 13
) (
   input  logic signed [W-1:0]         val,
   output logic [3:0]                  size,
   output logic [SYM_AMP_W-1:0]        amp
);

   logic [W-1:0]                mag;
   logic signed [SYM_AMP_W-1:0] val_ext;
   logic signed [SYM_AMP_W-1:0] val_m1;
   logic [SYM_AMP_W-1:0]        mask;

   always_comb begin
      // Most-negative input still yields the correct unsigned magnitude.
      mag     = val[W-1] ? $unsigned(-val) : $unsigned(val);
      size    = '0;
      for (int i = 0; i < W; i++)
         if (mag[i]) size = 4'(i + 1);
      val_ext = SYM_AMP_W'(val);
      val_m1  = val_ext - 16'sd1;
      mask    = (SYM_AMP_W'(1) << size) - SYM_AMP_W'(1);
      amp     = (val[W-1] ? $unsigned(val_m1) : $unsigned(val_ext)) & mask;
   end

endmodule

// File: rtl/jpeg_rle.sv
// Zig-zag coefficient stream -> JPEG DC/AC/ZRL/EOB symbol stream.
// Define JPEG_RLE_DC_DIFF_EN to code DC as a difference from the previous block.
module jpeg_rle
   import jpeg_enc_pkg::*;
#(
   parameter  int DCT_WIDTH       = 12,
   parameter  int SYM_TDATA_WIDTH = 32,
   localparam int ZZ_W            = ((DCT_WIDTH + 7) / 8) * 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic [ZZ_W-1:0]              zz_tdata,
   input  logic                         zz_tvalid,
   output logic                         zz_tready,
   input  logic                         zz_tuser,
   input  logic                         zz_tlast,
   output logic [SYM_TDATA_WIDTH-1:0]   sym_tdata,
   output logic                         sym_tvalid,
   input  logic                         sym_tready,
   output logic                         sym_tuser,
   output logic                         sym_tlast,
   output logic [SYM_TDATA_WIDTH/8-1:0] sym_tstrb,
   output logic [SYM_TDATA_WIDTH/8-1:0] sym_tkeep
);

   localparam int VW = DCT_WIDTH + 1;

   rle_state_t                  state, state_nxt;
   logic [5:0]                  idx, run, run_nxt;
   logic signed [DCT_WIDTH-1:0] coef, held_coef;
   logic                        held_last;
   logic                        rdy_en;
   logic                        out_free, in_fire, coef_nz;
   logic signed [VW-1:0]        dc_val, vli_in;
   logic [3:0]                  vli_size;
   logic [SYM_AMP_W-1:0]        vli_amp;
   rle_sym_t                    sym_q, sym_d;
   logic                        sym_vld, sym_user, sym_last;
   logic                        emit, user_d, last_d;

   assign coef    = $signed(zz_tdata[DCT_WIDTH-1:0]);
   assign coef_nz = |coef;

   generate
      if (ZZ_W > DCT_WIDTH) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^zz_tdata[ZZ_W-1:DCT_WIDTH];
      end
   endgenerate

   assign out_free  = !sym_vld || sym_tready;
   assign zz_tready = rdy_en && out_free && (state == ST_COEF);
   assign in_fire   = zz_tvalid && zz_tready;

`ifdef JPEG_RLE_DC_DIFF_EN
   logic signed [DCT_WIDTH-1:0] dc_pred;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i)                      dc_pred <= '0;
      else if (in_fire && idx == 6'd0)   dc_pred <= coef;

   // A frame start restarts prediction from zero.
   assign dc_val = VW'(coef) - (zz_tuser ? VW'(0) : VW'(dc_pred));
`else
   assign dc_val = VW'(coef);
`endif

   // One coder is enough: the held coefficient is only coded while input is stalled.
   always_comb begin
      if (state == ST_ZRL)    vli_in = VW'(held_coef);
      else if (idx == 6'd0)   vli_in = dc_val;
      else                    vli_in = VW'(coef);
   end

   jpeg_vli_enc #(.W(VW)) u_vli (
      .val  (vli_in),
      .size (vli_size),
      .amp  (vli_amp)
   );

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) state <= ST_COEF;
      else          state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_COEF: if (in_fire && idx != 6'd0 && coef_nz && run >= 6'd16) state_nxt = ST_ZRL;
         ST_ZRL:  if (out_free && run < 6'd16)                           state_nxt = ST_COEF;
         default: state_nxt = ST_COEF;
      endcase
   end

   always_comb begin
      sym_d   = '0;
      emit    = 1'b0;
      user_d  = 1'b0;
      last_d  = 1'b0;
      run_nxt = run;
      case (state)
         ST_COEF: if (in_fire) begin
            if (idx == 6'd0) begin
               emit       = 1'b1;
               sym_d.dc   = 1'b1;
               sym_d.size = vli_size;
               sym_d.amp  = vli_amp;
               user_d     = zz_tuser;
               run_nxt    = '0;
            end else if (!coef_nz) begin
               if (idx == 6'd63) begin
                  emit      = 1'b1;
                  sym_d.eob = 1'b1;
                  last_d    = zz_tlast;
                  run_nxt   = '0;
               end else begin
                  run_nxt = run + 6'd1;
               end
            end else if (run >= 6'd16) begin
               emit      = 1'b1;
               sym_d.zrl = 1'b1;
               sym_d.run = ZRL_RUN;
               run_nxt   = run - 6'd16;
            end else begin
               emit       = 1'b1;
               sym_d.run  = run[3:0];
               sym_d.size = vli_size;
               sym_d.amp  = vli_amp;
               last_d     = (idx == 6'd63) && zz_tlast;
               run_nxt    = '0;
            end
         end
         ST_ZRL: if (out_free) begin
            emit = 1'b1;
            if (run >= 6'd16) begin
               sym_d.zrl = 1'b1;
               sym_d.run = ZRL_RUN;
               run_nxt   = run - 6'd16;
            end else begin
               sym_d.run  = run[3:0];
               sym_d.size = vli_size;
               sym_d.amp  = vli_amp;
               last_d     = held_last;
               run_nxt    = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         rdy_en    <= 1'b0;
         idx       <= '0;
         run       <= '0;
         held_coef <= '0;
         held_last <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         run    <= run_nxt;
         if (in_fire) idx <= idx + 6'd1;
         if (state == ST_COEF && state_nxt == ST_ZRL) begin
            held_coef <= coef;
            held_last <= (idx == 6'd63) && zz_tlast;
         end
      end

   // Output slice: reloads on the same edge it is drained, no bubble.
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         sym_q    <= '0;
         sym_vld  <= 1'b0;
         sym_user <= 1'b0;
         sym_last <= 1'b0;
      end else if (emit) begin
         sym_q    <= sym_d;
         sym_vld  <= 1'b1;
         sym_user <= user_d;
         sym_last <= last_d;
      end else if (sym_tready) begin
         sym_vld  <= 1'b0;
      end

   assign sym_tdata  = SYM_TDATA_WIDTH'(sym_q);
   assign sym_tvalid = sym_vld;
   assign sym_tuser  = sym_user;
   assign sym_tlast  = sym_last;
   assign sym_tstrb  = '1;
   assign sym_tkeep  = '1;

endmodule

// File: doc/jpeg_rle.md
# jpeg_rle

Run-length/VLI symbol encoder, directly downstream of the zig-zag stage. Consumes one block of 64 signed coefficients in zig-zag order and emits JPEG entropy-coding symbols. Per block it emits one DC symbol (differential), AC (run, size, amplitude) symbols, ZRL (15,0) symbols and EOB (0,0). The Huffman stage consumes its output.

## Interface
- `DCT_WIDTH`, 12: signed coefficient width on input.
- `SYM_TDATA_WIDTH`, 32: output tdata width. Fixed layout:
  - [3:0] size
  - [7:4] run
  - [8] DC flag
  - [9] EOB flag
  - [10] ZRL flag
  - [15:11] zero
  - [31:16] amplitude, zero-extended above `size` bits
- `clk_i`  in  1  single clock.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `zz_i`  axi4_stream_if.slave  tdata = DCT_WIDTH rounded up to bytes  coefficient stream.
  - Low `DCT_WIDTH` bits are the signed value.
  - tuser marks index 0 of the first block of a frame.
  - tlast marks index 63 of the last block.
- `sym_o`  axi4_stream_if.master  `SYM_TDATA_WIDTH`  symbol stream.
  - tstrb and tkeep tied to all ones.

## Operation
- 6-bit index counter advances on each zz_i handshake and wraps 63→0. Zero-run counter is 6 bits.
- FSM states:
  - **COEF**: accept coefficients.
  - **ZRL**: zz_i.tready=0; emit ZRL, subtract 16 from run.
- Index 0:
  - diff = coef − dc_pred, computed at DCT_WIDTH+1 bits signed.
  - dc_pred <= coef.
  - dc_pred is treated as 0 when tuser is set on that beat.
  - Emit DC symbol: run=0, DC flag=1.
- Index 1..63, coef==0: run++, no output. If index==63, emit EOB (run 0, size 0, EOB flag).
- Index 1..63, coef!=0:
  - If run ≥ 16: hold the coefficient in a register and enter ZRL.
  - ZRL emits one symbol per output handshake until run < 16, then emits (run, size) and returns to COEF.
  - Otherwise emit (run, size) immediately.
  - run cleared after the symbol.
- Trailing zeros of a block produce no ZRL; EOB covers them. A nonzero coefficient at index 63 produces no EOB.
- Size and amplitude (VLI):
  - size = bit length of |v|; 0 for v=0.
  - Amplitude = v for v>0; (v−1) truncated to `size` bits for v<0.
- Frame sideband:
  - sym_o.tuser = 1 only on the DC symbol of a block whose index-0 beat had tuser.
  - sym_o.tlast = 1 on the final symbol of a block whose index-63 beat had tlast.
  - tlast on any other index is ignored.
- Reset (any time, including mid-block) clears index, run, dc_pred, FSM (→COEF) and the output register.

## Timing
- Output is a single register slice.
- zz_i.tready = (!sym_o.tvalid || sym_o.tready) && state==COEF.
- Latency: accepted coefficient → symbol valid next cycle.
- Throughput: 1 coefficient/cycle, except 1 stall cycle per ZRL (plus output backpressure).
- sym_o.tdata/tuser/tlast stay stable while tvalid && !tready.
- Reset values:
  - sym_o.tvalid=0, tdata=0, tuser=0, tlast=0.
  - zz_i.tready=1 one cycle after reset release.
- Simultaneous output handshake and new input: output register reloads in the same cycle, no bubble.

## Configuration
- `JPEG_RLE_DC_DIFF_EN` defined: DC coded as the difference from the previous block DC, as above.
- Not defined:
  - DC symbol carries the raw coefficient's size and amplitude.
  - dc_pred register is absent.
  - tuser still propagates.

## Structure
- Shared package `jpeg_enc_pkg` holds:
  - `rle_sym_t` packed struct for the tdata layout.
  - Field-position constants.
  - `ZRL_RUN=4'd15`.
  - FSM enum `rle_state_t`.
- One combinational sub-module `jpeg_vli_enc` (value → size, amplitude), parameterised on input width (DCT_WIDTH+1).

## Test plan
1. Block with tuser, DC=50, all AC=0 → DC symbol size=6, amp=0x32, tuser=1; then EOB with EOB flag. Exactly 2 symbols.
2. Next block DC=45, AC=0 → diff −5: size=3, amp=3'b010. Macro off → size=6, amp=45.
3. Index 20 = 3, indices 1..19 = 0, rest 0:
   - ZRL (15,0), then run=3, size=2, amp=3, then EOB.
   - zz_i.tready low exactly 1 cycle.
4. Index 63 = −1, indices 1..62 = 0, tlast on index 63:
   - 3× ZRL, then run=14, size=1, amp=0 with tlast=1.
   - No EOB.
5. sym_o.tready toggled pseudo-randomly over 8 blocks → symbol sequence identical to the free-running reference model; tdata stable under stall.
6. Assert rst_n_i at index 30 mid-block, restart with a fresh block DC=7 → outputs zero during reset; DC diff=7 (predictor cleared), size=3, amp=7.
